// File: rtl/video_timing_pkg.sv
// Shared timing constants, sync polarities and FSM encoding for the
// 1024x768@60 raster generator.
package video_timing_pkg;

  // 1024x768@60 horizontal timing, in pixels
  localparam int unsigned XGA_H_ACTIVE = 1024;
  localparam int unsigned XGA_H_FP     = 24;
  localparam int unsigned XGA_H_SYNC   = 136;
  localparam int unsigned XGA_H_BP     = 160;
  localparam int unsigned XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;

  // 1024x768@60 vertical timing, in lines
  localparam int unsigned XGA_V_ACTIVE = 768;
  localparam int unsigned XGA_V_FP     = 3;
  localparam int unsigned XGA_V_SYNC   = 6;
  localparam int unsigned XGA_V_BP     = 29;
  localparam int unsigned XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

  // Sync active levels (0 = active-low)
  localparam logic XGA_HS_POL = 1'b0;
  localparam logic XGA_VS_POL = 1'b0;

  // Consecutive locked cycles required before the raster may start
  localparam int unsigned XGA_LOCK_WAIT = 1024;

  // Raster controller states
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    IDLE      = 2'd1,
    RUN       = 2'd2
  } vt_state_e;

endpackage

// File: rtl/video_timing_gen_lock_qualifier.sv
// PLL lock qualifier: 2-flop synchroniser for the asynchronous lock input
// followed by a saturating counter of consecutive locked cycles.
module lock_qualifier #(
  parameter int unsigned LOCK_WAIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  output logic lock_sync,
  output logic lock_ok
);

  localparam int unsigned CW = $clog2(LOCK_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_WAIT);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] count_q, count_d;

  // Shift the raw lock through the synchroniser; count while the synchronised lock is high
  always_comb begin
    sync_d  = {sync_q[0], pll_locked};
    count_d = count_q;
    if (!sync_q[1]) begin
      count_d = '0;
    end else if (count_q != CNT_MAX) begin
      count_d = count_q + CW'(1);
    end
  end

  // Synchroniser and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      count_q <= '0;
    end else begin
      sync_q  <= sync_d;
      count_q <= count_d;
    end
  end

  assign lock_sync = sync_q[1];
  // Looks at the value the counter takes on this edge, so the controller
  // leaves WAIT_LOCK on the same edge the counter reaches LOCK_WAIT.
  assign lock_ok   = (count_d == CNT_MAX);

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: waits for a qualified PLL lock, then produces
// registered hsync/vsync/de, pixel coordinates and line/frame markers.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = XGA_H_ACTIVE,
  parameter int unsigned H_FP      = XGA_H_FP,
  parameter int unsigned H_SYNC    = XGA_H_SYNC,
  parameter int unsigned H_BP      = XGA_H_BP,
  parameter int unsigned V_ACTIVE  = XGA_V_ACTIVE,
  parameter int unsigned V_FP      = XGA_V_FP,
  parameter int unsigned V_SYNC    = XGA_V_SYNC,
  parameter int unsigned V_BP      = XGA_V_BP,
  parameter logic        HS_POL    = XGA_HS_POL,
  parameter logic        VS_POL    = XGA_VS_POL,
  parameter int unsigned LOCK_WAIT = XGA_LOCK_WAIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pll_locked,
  input  logic        enable,
  output logic        running,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Raster must fit the 11-bit x and 10-bit y outputs
  if (H_TOTAL > 2048) begin : g_h_total_too_large
    $error("H_TOTAL exceeds the 11-bit x range");
  end
  if (V_TOTAL > 1024) begin : g_v_total_too_large
    $error("V_TOTAL exceeds the 10-bit y range");
  end
  if (LOCK_WAIT < 1) begin : g_lock_wait_too_small
    $error("LOCK_WAIT must be at least 1");
  end

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_L  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEGIN = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT_L  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic lock_sync;
  logic lock_ok;

  lock_qualifier #(
    .LOCK_WAIT (LOCK_WAIT)
  ) u_lock_qualifier (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .lock_sync  (lock_sync),
    .lock_ok    (lock_ok)
  );

  vt_state_e   state_q, state_d;
  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;

  logic        running_q, running_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  logic frame_end;
  logic active;

  assign frame_end = (h_q == H_LAST) && (v_q == V_LAST);
  // A lock drop kills the outputs on the same edge that the FSM abandons the frame
  assign active    = (state_q == RUN) && lock_sync;

  // Next state and raster counters; lock loss overrides everything
  always_comb begin
    state_d = state_q;
    h_d     = '0;
    v_d     = '0;
    if (!lock_sync) begin
      state_d = WAIT_LOCK;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (lock_ok) state_d = IDLE;
        end
        IDLE: begin
          if (enable) state_d = RUN;
        end
        RUN: begin
          if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
          end else begin
            h_d = h_q + 11'd1;
            v_d = v_q;
          end
          if (frame_end && !enable) state_d = IDLE;
        end
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  // Output decode of the current position; everything parks at reset values outside RUN
  always_comb begin
    running_d     = active;
    x_d           = active ? h_q : 11'd0;
    y_d           = active ? v_q : 10'd0;
    de_d          = active && (h_q < H_ACT_L) && (v_q < V_ACT_L);
    hsync_d       = (active && (h_q >= HS_BEGIN) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
    vsync_d       = (active && (v_q >= VS_BEGIN) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
    line_start_d  = active && (h_q == 11'd0);
    frame_start_d = active && (h_q == 11'd0) && (v_q == 10'd0);
  end

  // FSM state and raster counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  // Output registers, one cycle behind the counters
  always_ff @(posedge clk) begin
    if (rst) begin
      running_q     <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      running_q     <= running_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign running     = running_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a scaled-down raster.
`timescale 1ns/1ps
module tb_video_timing_gen;

  localparam int H_ACT = 16;
  localparam int H_FPW = 2;
  localparam int H_SW  = 3;
  localparam int H_BPW = 4;
  localparam int H_TOT = H_ACT + H_FPW + H_SW + H_BPW;
  localparam int V_ACT = 6;
  localparam int V_FPW = 1;
  localparam int V_SW  = 2;
  localparam int V_BPW = 2;
  localparam int V_TOT = V_ACT + V_FPW + V_SW + V_BPW;
  localparam int LOCK_CYC  = 8;
  localparam int START_LAT = LOCK_CYC + 4;

  // {running, hsync, vsync, de, line_start, frame_start, x, y} outside RUN
  localparam logic [26:0] EXP_IDLE = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 10'd0};

  logic        clk = 1'b0;
  logic        rst;
  logic        pll_locked;
  logic        enable;
  logic        running, hsync, vsync, de, line_start, frame_start;
  logic [10:0] x;
  logic [9:0]  y;

  video_timing_gen #(
    .H_ACTIVE  (H_ACT),
    .H_FP      (H_FPW),
    .H_SYNC    (H_SW),
    .H_BP      (H_BPW),
    .V_ACTIVE  (V_ACT),
    .V_FP      (V_FPW),
    .V_SYNC    (V_SW),
    .V_BP      (V_BPW),
    .HS_POL    (1'b0),
    .VS_POL    (1'b0),
    .LOCK_WAIT (LOCK_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .enable      (enable),
    .running     (running),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [26:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   pos_x    = 0;
  int   pos_y    = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
  endtask

  function automatic logic [26:0] obs_vec();
    return {running, hsync, vsync, de, line_start, frame_start, x, y};
  endfunction

  // Expected output word for a RUN-state position
  function automatic logic [26:0] exp_run(input int px, input int py);
    logic hs_on, vs_on, de_on;
    de_on = (px < H_ACT) && (py < V_ACT);
    hs_on = (px >= H_ACT + H_FPW) && (px < H_ACT + H_FPW + H_SW);
    vs_on = (py >= V_ACT + V_FPW) && (py < V_ACT + V_FPW + V_SW);
    return {1'b1, ~hs_on, ~vs_on, de_on, (px == 0), (px == 0) && (py == 0), 11'(px), 10'(py)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic [26:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop();
    exp_t e;
    e = sb_q.pop_front();
    check_eq(e.tag, {5'd0, obs_vec()}, {5'd0, e.val});
  endtask

  // One raster cycle with the DUT expected to be running
  task automatic run_step(input string tag);
    if (pos_x == H_TOT - 1) begin
      pos_x = 0;
      pos_y = (pos_y == V_TOT - 1) ? 0 : pos_y + 1;
    end else begin
      pos_x++;
    end
    sb_push(tag, exp_run(pos_x, pos_y));
    tick();
    sb_pop();
  endtask

  // One cycle with the DUT expected to be parked
  task automatic idle_step(input string tag);
    sb_push(tag, EXP_IDLE);
    tick();
    sb_pop();
  endtask

  task automatic run_to(input int tx, input int ty, input string tag);
    while (!(pos_x == tx && pos_y == ty)) run_step(tag);
  endtask

  // Count edges until running rises (bounded), then check the first output cycle
  task automatic wait_running(input string tag, input int lat);
    int n;
    n = 0;
    while (running !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check_eq(tag, n, lat);
    pos_x = 0;
    pos_y = 0;
    sb_push({tag, "_first"}, exp_run(0, 0));
    sb_pop();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int de_cnt, vs_cnt, vs_first, hs_cnt, hs_first, fs_last, period;
    rst        = 1'b1;
    pll_locked = 1'b1;
    enable     = 1'b1;
    tick();
    tick();
    idle_step("reset_state");

    // Startup latency from reset release with the PLL already locked
    rst = 1'b0;
    wait_running("start_latency", START_LAT);
    $display("scenario startup: first frame at cycle %0d", START_LAT);

    // Full frame against the model plus aggregate strobe counts
    de_cnt = 0; vs_cnt = 0; vs_first = -1; hs_cnt = 0; hs_first = -1; fs_last = -1;
    for (int c = 0; c < H_TOT * V_TOT; c++) begin
      if (c > 0) run_step("frame");
      if (de) de_cnt++;
      if (!vsync) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = c;
      end
      if (!hsync && pos_y == 0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = pos_x;
      end
      if (frame_start) fs_last = c;
    end
    run_step("frame_wrap");
    period = frame_start ? (H_TOT * V_TOT - fs_last) : -1;
    check_eq("de_count", de_cnt, H_ACT * V_ACT);
    check_eq("hsync_width", hs_cnt, H_SW);
    check_eq("hsync_start_x", hs_first, H_ACT + H_FPW);
    check_eq("vsync_cycles", vs_cnt, V_SW * H_TOT);
    check_eq("vsync_start", vs_first, (V_ACT + V_FPW) * H_TOT);
    check_eq("frame_period", period, H_TOT * V_TOT);
    $display("scenario full_frame: de=%0d vsync_cycles=%0d", de_cnt, vs_cnt);

    // enable dropped mid-frame: frame completes, then raster parks
    run_to(0, 2, "en_run");
    enable = 1'b0;
    run_to(H_TOT - 1, V_TOT - 1, "en_drain");
    for (int i = 0; i < 10; i++) idle_step("en_idle");
    enable = 1'b1;
    wait_running("reenable_latency", 2);
    $display("scenario enable_drop: frame drained and restarted");

    // Lock loss mid-frame
    run_to(5, 4, "pre_loss");
    pll_locked = 1'b0;
    run_step("loss_d1");
    run_step("loss_d2");
    idle_step("loss_clear");
    for (int i = 0; i < 3; i++) idle_step("loss_hold");
    pll_locked = 1'b1;
    wait_running("relock_latency", START_LAT);
    $display("scenario lock_loss: outputs cleared, raster requalified");

    // One-cycle lock glitch while the qualifier is counting
    rst = 1'b1;
    idle_step("glitch_rst");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) idle_step("glitch_count");
    pll_locked = 1'b0;
    idle_step("glitch_low");
    pll_locked = 1'b1;
    wait_running("glitch_latency", START_LAT);
    $display("scenario lock_glitch: qualification restarted");

    // Reset mid-frame
    run_to(10, 3, "pre_rst");
    rst = 1'b1;
    idle_step("rst_midframe");
    idle_step("rst_hold");
    rst = 1'b0;
    wait_running("rst_requal", START_LAT);
    for (int i = 0; i < 5; i++) run_step("post_rst");
    $display("scenario reset_midframe: requalified after reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
